button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Input-side counterpart to the LED driver: conditions NUM_BTN active-low pushbutton pins into clean, synchronous, active-high levels and single-cycle press/release events.
- Sits between the board button pins and user logic, for example the mode or speed control of the LED pattern.
- Each button has its own 2-FF synchronizer, debounce counter and edge detector.
- A shared 16-bit counter tallies accepted presses.

Parameters:
- CLOCK_HZ, 100000000, clock frequency in Hz; used only to derive the defaults below.
- NUM_BTN, 4, number of buttons, 1..32.
- DEBOUNCE_CYCLES, CLOCK_HZ/100, consecutive cycles a new level must persist before it is accepted; minimum 1.
- LONG_CYCLES, CLOCK_HZ, hold time for a long-press event; used only when BUTTON_LONGPRESS_EN is defined; minimum 1.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- btn_pin  input  NUM_BTN  raw button pins, active low (0 = pressed), asynchronous to clk
- btn  output  NUM_BTN  debounced level, active high (1 = pressed)
- press  output  NUM_BTN  one-cycle pulse when btn[i] goes 0->1
- release  output  NUM_BTN  one-cycle pulse when btn[i] goes 1->0
- long_press  output  NUM_BTN  one-cycle pulse after btn[i] has been held LONG_CYCLES cycles
- press_count  output  16  running total of accepted presses, wraps

Behaviour:
- Reset (resetn=0, asynchronous assert, synchronous release by system):
  - synchronizer flops = 1 (idle/released)
  - btn = 0; press, release, long_press = 0
  - debounce and hold counters = 0; press_count = 0
- Synchronizer: sync[i] = ~(btn_pin[i] after two flops).
- Debounce, per button, each clock:
  - If sync == btn: counter cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn toggles, counter cleared to 0, and the matching pulse fires in the same cycle (press for 0->1, release for 1->0).
  - Otherwise: counter increments.
  - Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES-1.
- Latency: if btn_pin changes and holds, first sampled at edge k, then btn and the pulse update at edge k+1+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=1, that is edge k+2.
- Glitches: any excursion shorter than DEBOUNCE_CYCLES cycles, or bouncing that returns to the btn level, restarts the counter. It causes no btn change and no pulse.
- press and release are mutually exclusive per button per cycle. Each is high for exactly one cycle.
- Buttons are fully independent. Simultaneous events on several buttons all fire in the same cycle.
- press_count: each cycle, press_count <= press_count + popcount(press).
  - Wraps modulo 2^16; 16'hFFFF + 2 = 16'h0001.
  - Releases do not change it.
- Reset mid-debounce discards the partial count. After reset, a held button re-qualifies through the full debounce latency.

Optional Feature:
- Macro: BUTTON_LONGPRESS_EN.
- Defined: per-button hold counter, width $clog2(LONG_CYCLES+1).
  - Cleared to 0 in the press cycle and whenever btn=0.
  - While btn=1 and hold < LONG_CYCLES, hold increments.
  - long_press[i] pulses for one cycle in the cycle the counter reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after the press pulse.
  - The counter then saturates, so there is exactly one long_press per press.
  - A release before that point produces no long_press.
- Undefined: long_press tied to 0, no hold counters synthesized. The port is present in both builds.

Test Plan (NUM_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20):
1. Reset and idle: hold btn_pin=4'hF, resetn=0 then 1 -> btn=0; press, release, long_press=0; press_count=0 for 50 cycles.
2. Clean press and release:
   - drive btn_pin[0]=0 first sampled at edge k -> btn[0]=1 and press[0]=1 at edge k+5 only; press_count=1
   - raise btn_pin[0] later -> release[0] one cycle at the same latency, btn[0]=0, press_count stays 1.
3. Bounce: toggle btn_pin[1] with low runs of 3 cycles, 10 times, then hold low -> no btn[1] or press[1] change during bouncing; a single press[1] exactly 5 edges after the final stable low is first sampled.
4. Simultaneous events and wrap:
   - force press_count to 16'hFFFE via 65534 presses or a preloaded backdoor
   - press buttons 0..2 in the same cycle -> three press bits in one cycle, press_count=16'h0001.
5. Reset mid-operation: assert resetn=0 two cycles into a debounce of btn_pin[2]=0, release resetn with the pin still low -> btn[2]=0 immediately; press[2] fires a full 5 edges after resetn release.
6. Long press:
   - With BUTTON_LONGPRESS_EN, hold btn_pin[3] low -> long_press[3] one cycle, 20 cycles after press[3]; none afterwards while held.
   - Release after 15 cycles -> no long_press.
   - Without the macro -> long_press=0 throughout.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: NUM_BTN active-low pushbutton pins -> synchronized, debounced
// active-high levels with one-cycle press / release events and a shared 16-bit
// press tally. Optional long-press detection is compiled in with the macro
// BUTTON_LONGPRESS_EN; without it long_press is tied low and no hold counters exist.
// The release event port is named "released" because "release" is a reserved word.

// Per-button lane: 2-FF synchronizer, debounce counter, edge pulses, optional hold timer.
module button_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic btn,
  output logic press,
  output logic released,
  output logic long_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic          sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; resets to the released (high) pin level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_ff <= 2'b11;
    else         sync_ff <= {sync_ff[0], pin};
  end

  assign sync = ~sync_ff[1];

  // Debounce: a new level must persist DEBOUNCE_CYCLES cycles; any return restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      btn      <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= 1'b0;
      released <= 1'b0;
      if (sync == btn) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt      <= '0;
        btn      <= sync;
        press    <= sync;
        released <= ~sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BUTTON_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold;

  // Hold timer: zero while released (so zero in the press cycle), counts while
  // pressed and saturates, so long_press fires once, LONG_CYCLES after press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!btn) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
        if (hold == HOLD_LAST) long_press <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// Top: array of lanes plus the shared press tally.
module button_debouncer #(
  parameter int          CLOCK_HZ        = 100_000_000,
  parameter int          NUM_BTN         = 4,
  parameter int          DEBOUNCE_CYCLES = CLOCK_HZ / 100,
  parameter int          LONG_CYCLES     = CLOCK_HZ,
  parameter logic [15:0] COUNT_RESET     = 16'h0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] btn_pin,
  output logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] released,
  output logic [NUM_BTN-1:0] long_press,
  output logic [15:0]        press_count
);
  logic [15:0] press_sum;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    button_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .pin       (btn_pin[i]),
      .btn       (btn[i]),
      .press     (press[i]),
      .released  (released[i]),
      .long_press(long_press[i])
    );
  end

  // Popcount of this cycle's press pulses.
  always_comb begin
    press_sum = '0;
    for (int i = 0; i < NUM_BTN; i++) press_sum = press_sum + 16'(press[i]);
  end

  // Running press tally, wraps modulo 2^16.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) press_count <= COUNT_RESET;
    else         press_count <= press_count + press_sum;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (NUM_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// A second instance preloads press_count near wrap for the counter-wrap step.
// Long-press expectations follow BUTTON_LONGPRESS_EN.
module tb_button_debouncer;
`ifdef BUTTON_LONGPRESS_EN
  localparam logic LP_EN = 1'b1;
`else
  localparam logic LP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  btn_pin = 4'hF, btn, press, released, long_press;
  logic [15:0] press_count;
  logic [3:0]  pin_w = 4'hF, btn_w, press_w, released_w, long_w;
  logic [15:0] count_w;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_debouncer #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .resetn(resetn), .btn_pin(btn_pin), .btn(btn), .press(press),
    .released(released), .long_press(long_press), .press_count(press_count));

  button_debouncer #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
                     .COUNT_RESET(16'hFFFE)) dut_w (
    .clk(clk), .resetn(resetn), .btn_pin(pin_w), .btn(btn_w), .press(press_w),
    .released(released_w), .long_press(long_w), .press_count(count_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pin was just driven: expect btn/pulses to change only at the n-th edge.
  task automatic watch(input string tag, input int n, input logic [3:0] b0,
                       input logic [3:0] b1, input logic [3:0] pr, input logic [3:0] rl);
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (i < n) begin
        chk({tag, "_wait_btn"}, btn, b0);
        chk({tag, "_wait_pulse"}, {press, released}, 8'h00);
      end else begin
        chk({tag, "_btn"}, btn, b1);
        chk({tag, "_press"}, press, pr);
        chk({tag, "_release"}, released, rl);
      end
      chk({tag, "_long"}, long_press, 4'h0);
    end
    step(1);
    chk({tag, "_one_cycle"}, {press, released}, 8'h00);
    chk({tag, "_btn_hold"}, btn, b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset and idle
    step(3);
    chk("rst_btn", btn, 4'h0);
    chk("rst_pulses", {press, released, long_press}, 12'h000);
    chk("rst_count", press_count, 16'h0000);
    chk("rst_count_w", count_w, 16'hFFFE);
    resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("idle_outs", {btn, press, released, long_press}, 16'h0000);
      chk("idle_count", press_count, 16'h0000);
    end

    // 2. clean press / release of button 0: first sampled at next edge k, update at k+5
    btn_pin[0] = 1'b0;
    watch("p0", 6, 4'h0, 4'h1, 4'h1, 4'h0);
    chk("p0_count", press_count, 16'd1);
    step(3);
    btn_pin[0] = 1'b1;
    watch("r0", 6, 4'h1, 4'h0, 4'h0, 4'h1);
    step(1);
    chk("r0_count", press_count, 16'd1);

    // 3. bounce on button 1: 3-cycle low runs never qualify
    for (int r = 0; r < 10; r++) begin
      btn_pin[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        step(1);
        chk("bounce_lo", {btn, press}, 8'h00);
      end
      btn_pin[1] = 1'b1;
      for (int c = 0; c < 2; c++) begin
        step(1);
        chk("bounce_hi", {btn, press}, 8'h00);
      end
    end
    btn_pin[1] = 1'b0;
    watch("p1", 6, 4'h0, 4'h2, 4'h2, 4'h0);
    chk("p1_count", press_count, 16'd2);
    btn_pin[1] = 1'b1;
    watch("r1", 6, 4'h2, 4'h0, 4'h0, 4'h2);

    // 4. simultaneous presses on 0..2, count wraps FFFE + 3 = 0001
    pin_w[2:0] = 3'b000;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("wrap_press", press_w, (i == 6) ? 4'h7 : 4'h0);
      chk("wrap_count_pre", count_w, 16'hFFFE);
    end
    step(1);
    chk("wrap_count", count_w, 16'h0001);
    chk("wrap_one_cycle", press_w, 4'h0);
    chk("wrap_btn", btn_w, 4'h7);
    pin_w = 4'hF;

    // 5. reset two cycles into a debounce of button 2
    btn_pin[2] = 1'b0;
    step(2);
    resetn = 1'b0;
    #1;
    chk("mid_rst_btn", btn, 4'h0);
    chk("mid_rst_count", press_count, 16'h0000);
    chk("mid_rst_count_w", count_w, 16'hFFFE);
    step(2);
    resetn = 1'b1;
    watch("p2", 6, 4'h0, 4'h4, 4'h4, 4'h0);
    chk("p2_count", press_count, 16'd1);
    btn_pin[2] = 1'b1;
    watch("r2", 6, 4'h4, 4'h0, 4'h0, 4'h4);

    // 6a. long press on button 3: one pulse 20 cycles after press, none after
    btn_pin[3] = 1'b0;
    watch("p3", 6, 4'h0, 4'h8, 4'h8, 4'h0);
    for (int i = 2; i <= 30; i++) begin
      step(1);
      chk("long_held", long_press, (LP_EN && i == 20) ? 4'h8 : 4'h0);
    end
    btn_pin[3] = 1'b1;
    watch("r3", 6, 4'h8, 4'h0, 4'h0, 4'h8);

    // 6b. release after 15 cycles: no long press
    btn_pin[3] = 1'b0;
    watch("p3b", 6, 4'h0, 4'h8, 4'h8, 4'h0);
    for (int i = 2; i <= 30; i++) begin
      if (i == 10) btn_pin[3] = 1'b1;
      step(1);
      chk("long_short", long_press, 4'h0);
      if (i == 15) chk("short_release", {btn, released}, 8'h08);
    end
    chk("final_count", press_count, 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
